// File: rtl/code_loader.sv
// ============================================================================
//  Module      : code_loader
//  Description : Streams a framed program image from the UART receiver into
//                the code RAM write port, holding the CPU until a load passes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_loader #(
    parameter int          ADDR_WIDTH     = 13,
    parameter logic [7:0]  MAGIC          = 8'hB5,
    parameter int          TIMEOUT_CYCLES = 2700000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_ok,
    output logic                  load_err
);

    localparam int                  c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]         c_max_len  = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CSUM    = 3'd5
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_len_hi;
    logic [15:0]            r_len;
    logic [7:0]             r_data_hi;
    logic [ADDR_WIDTH:0]    r_index;
    logic [7:0]             r_csum;
    logic [c_tmo_w-1:0]     r_tmo_cnt;

    logic [15:0]            w_len_full;
    logic [ADDR_WIDTH:0]    w_next_index;
    logic                   w_last_word;
    logic                   w_timeout;

    assign w_len_full   = {r_len_hi, rx_data};
    assign w_next_index = r_index + 1'b1;
    // Index carries one extra bit so a full 2^ADDR_WIDTH load terminates without wrapping.
    assign w_last_word  = (17'(w_next_index) == {1'b0, r_len});
    assign w_timeout    = (r_state != S_IDLE) && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_len_hi  <= '0;
            r_len     <= '0;
            r_data_hi <= '0;
            r_index   <= '0;
            r_csum    <= '0;
            r_tmo_cnt <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;

            if (r_state == S_IDLE || rx_valid) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == MAGIC) begin
                            r_state  <= S_LEN_HI;
                            r_csum   <= '0;
                            load_ok  <= 1'b0;
                            load_err <= 1'b0;
                            cpu_hold <= 1'b1;
                        end
                    end
                    S_LEN_HI: begin
                        r_len_hi <= rx_data;
                        r_csum   <= r_csum ^ rx_data;
                        r_state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        r_len  <= w_len_full;
                        r_csum <= r_csum ^ rx_data;
                        if ({1'b0, w_len_full} > c_max_len) begin
                            load_err <= 1'b1;
                            r_state  <= S_IDLE;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_index <= '0;
                            r_state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        r_data_hi <= rx_data;
                        r_csum    <= r_csum ^ rx_data;
                        r_state   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        r_csum  <= r_csum ^ rx_data;
                        wr_en   <= 1'b1;
                        wr_addr <= r_index[ADDR_WIDTH-1:0];
                        wr_data <= {r_data_hi, rx_data};
                        r_index <= w_next_index;
                        r_state <= w_last_word ? S_CSUM : S_DATA_HI;
                    end
                    S_CSUM: begin
                        if (rx_data == r_csum) begin
                            load_done <= 1'b1;
                            load_ok   <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_timeout) begin
                load_err <= 1'b1;
                r_state  <= S_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_code_loader.sv
// ============================================================================
//  Module      : tb_code_loader
//  Description : Self-checking bench for code_loader: vector table, directed
//                corner sequences and randomized frames against a frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_loader;

    localparam int         T  = 40;
    localparam int         AW = 13;
    localparam logic [7:0] MG = 8'hB5;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_ok;
    logic          load_err;

    code_loader #(
        .ADDR_WIDTH    (AW),
        .MAGIC         (MG),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_ok  (load_ok),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    typedef struct {
        logic [63:0] bytes;   // first byte in the top octet
        int          n;
        int          nw;
        int          done;
        bit          ok;
        bit          err;
        bit          hold;
    } vec_t;

    int   nchecks = 0;
    int   nfail   = 0;
    int   done_cnt;
    wr_t  act_q[$];
    wr_t  exp_q[$];
    logic prev_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write/pulse monitor, sampled just after the active edge.
    always @(posedge clk) begin
        wr_t w;
        #1;
        if (!reset) begin
            if (wr_en) begin
                w.a = wr_addr;
                w.d = wr_data;
                act_q.push_back(w);
            end
            if (load_done) done_cnt++;
            if (prev_hold && !cpu_hold) check("hold_fall_with_done", 32'(load_done), 32'd1);
        end
        prev_hold = cpu_hold;
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level reference: finds the first MAGIC, decodes LEN and words, checks XOR.
    task automatic model(input logic [7:0] fb[$], output bit framed, output bit good);
        int         i;
        int         len;
        logic [7:0] x;
        wr_t        w;
        i      = 0;
        framed = 1'b0;
        good   = 1'b0;
        exp_q.delete();
        while (i < fb.size() && fb[i] != MG) i++;
        if (i + 2 >= fb.size()) return;
        framed = 1'b1;
        len    = int'({fb[i+1], fb[i+2]});
        if (len > (1 << AW)) return;
        x = fb[i+1] ^ fb[i+2];
        for (int k = 0; k < len; k++) begin
            w.a = AW'(k);
            w.d = {fb[i+3+2*k], fb[i+4+2*k]};
            x   = x ^ fb[i+3+2*k] ^ fb[i+4+2*k];
            exp_q.push_back(w);
        end
        good = (fb[i+3+2*len] == x);
    endtask

    task automatic cmp_writes(input string name);
        int mism;
        mism = 0;
        check({name, "_wr_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        if (act_q.size() == exp_q.size()) begin
            foreach (act_q[k]) if (act_q[k] !== exp_q[k]) mism++;
        end else begin
            mism = -1;
        end
        check({name, "_wr_content_mismatches"}, 32'(mism), 32'd0);
    endtask

    initial begin
        vec_t       tbl[8];
        logic [7:0] fb[$];
        bit         framed, good;
        bit         e_ok, e_err, e_hold;
        logic [7:0] b, x;
        int         len;

        tbl[0] = '{64'hB5_00_02_12_34_AB_CD_42, 8, 2, 1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{64'hB5_00_02_12_34_AB_CD_43, 8, 2, 0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{64'hB5_20_01_00_00_00_00_00, 3, 0, 0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{64'hB5_00_00_00_00_00_00_00, 4, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{64'h00_FF_12_00_00_00_00_00, 3, 0, 0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{64'hB5_00_01_AA_55_FE_00_00, 6, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{64'hB5_00_01_AA_55_FF_00_00, 6, 1, 0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{64'hB5_00_02_12_34_AB_CD_42, 8, 2, 1, 1'b1, 1'b0, 1'b0};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        done_cnt = 0;
        idle(3);
        check("reset_outputs", 32'({wr_en, wr_addr, wr_data, cpu_hold, load_done, load_ok, load_err}), 32'd0);
        reset = 1'b0;
        idle(2);
        check("powerup_hold", 32'(cpu_hold), 32'd0);

        // Cycle-accurate walk through the reference frame.
        act_q.delete();
        send(8'hB5); send(8'h00); send(8'h02); send(8'h12);
        check("t1_hold_during_load", 32'(cpu_hold), 32'd1);
        send(8'h34);
        check("t1_w0", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 13'h0000, 16'h1234}));
        send(8'hAB);
        check("t1_no_write_after_hi", 32'(wr_en), 32'd0);
        send(8'hCD);
        check("t1_w1", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 13'h0001, 16'hABCD}));
        send(8'h42);
        check("t1_done", 32'({load_done, load_ok, load_err, cpu_hold}), 32'b1100);
        idle(1);
        check("t1_done_one_cycle", 32'(load_done), 32'd0);

        // Table-driven frames.
        for (int v = 0; v < 8; v++) begin
            act_q.delete();
            done_cnt = 0;
            fb.delete();
            for (int j = 0; j < tbl[v].n; j++) begin
                b = tbl[v].bytes[63-8*j -: 8];
                fb.push_back(b);
                send(b);
            end
            idle(3);
            model(fb, framed, good);
            check($sformatf("v%0d_nw", v), 32'(act_q.size()), 32'(tbl[v].nw));
            check($sformatf("v%0d_done", v), 32'(done_cnt), 32'(tbl[v].done));
            check($sformatf("v%0d_status", v), 32'({load_ok, load_err, cpu_hold}),
                  32'({tbl[v].ok, tbl[v].err, tbl[v].hold}));
            cmp_writes($sformatf("v%0d", v));
        end

        // Timeout fires exactly T cycles after the last byte.
        send(8'hB5); send(8'h00); send(8'h01); send(8'h12);
        repeat (T - 1) @(negedge clk);
        check("t4_no_err_before_expiry", 32'(load_err), 32'd0);
        @(negedge clk);
        check("t4_err_at_expiry", 32'({load_err, cpu_hold}), 32'b11);
        // Byte on the expiry cycle rescues the frame.
        send(8'hB5); send(8'h00); send(8'h01); send(8'h12);
        repeat (T - 1) @(negedge clk);
        send(8'h34);
        check("t4_rescue_write", 32'({load_err, wr_en, wr_data}), 32'({1'b0, 1'b1, 16'h1234}));
        send(8'h27);
        check("t4_rescue_done", 32'({load_done, load_ok, load_err, cpu_hold}), 32'b1100);

        // Junk in IDLE after reset, then reset mid-frame.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        send(8'h00); send(8'hFF); send(8'h12);
        idle(2);
        check("t5_junk_ignored", 32'({wr_en, cpu_hold, load_done, load_ok, load_err}), 32'd0);
        act_q.delete();
        send(8'hB5); send(8'h00); send(8'h04); send(8'h11); send(8'h22); send(8'h33);
        reset = 1'b1;
        send(8'h44);
        check("t5_reset_outputs", 32'({wr_en, wr_addr, wr_data, cpu_hold, load_done, load_ok, load_err}), 32'd0);
        reset = 1'b0;
        send(8'h44); send(8'h55);
        idle(3);
        check("t5_writes_after_reset", 32'(act_q.size()), 32'd1);

        // Full-size image, one byte every cycle.
        act_q.delete();
        done_cnt = 0;
        fb.delete();
        fb.push_back(MG); fb.push_back(8'h20); fb.push_back(8'h00);
        x = 8'h20;
        for (int k = 0; k < (1 << AW); k++) begin
            logic [15:0] wd;
            wd = 16'(k) ^ 16'hA5C3;
            fb.push_back(wd[15:8]);
            fb.push_back(wd[7:0]);
            x = x ^ wd[15:8] ^ wd[7:0];
        end
        fb.push_back(x);
        foreach (fb[k]) send(fb[k]);
        idle(3);
        model(fb, framed, good);
        check("t6_model_good", 32'(good), 32'd1);
        cmp_writes("t6");
        check("t6_done", 32'({32'(done_cnt), load_ok, load_err, cpu_hold}), 32'({32'd1, 3'b100}));

        // Randomized frames with gaps and leading junk.
        e_ok = load_ok; e_err = load_err; e_hold = cpu_hold;
        for (int r = 0; r < 40; r++) begin
            act_q.delete();
            done_cnt = 0;
            fb.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == MG) b = 8'h00;
                fb.push_back(b);
            end
            fb.push_back(MG);
            if ($urandom_range(0, 7) == 0) begin
                len = (1 << AW) + 1 + $urandom_range(0, 100);
                fb.push_back(8'(len >> 8));
                fb.push_back(8'(len));
            end else begin
                len = $urandom_range(0, 5);
                fb.push_back(8'(len >> 8));
                fb.push_back(8'(len));
                x = 8'(len >> 8) ^ 8'(len);
                for (int k = 0; k < 2 * len; k++) begin
                    b = 8'($urandom);
                    fb.push_back(b);
                    x = x ^ b;
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                fb.push_back(x);
            end
            foreach (fb[k]) begin
                send(fb[k]);
                idle($urandom_range(0, 3));
            end
            idle(3);
            model(fb, framed, good);
            if (framed) begin
                e_ok = good; e_err = !good; e_hold = !good;
            end
            check($sformatf("r%0d_done", r), 32'(done_cnt), 32'(good));
            check($sformatf("r%0d_status", r), 32'({load_ok, load_err, cpu_hold}),
                  32'({e_ok, e_err, e_hold}));
            cmp_writes($sformatf("r%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule

`default_nettype wire
